// File: rtl/firc_if.sv
// Sample, coefficient and result signals of the complex FIR core.
// The source and consumer side uses master; the core uses slave.
interface firc_if;
    logic               PushIn;
    logic               StopIn;
    logic signed [23:0] SampI;
    logic signed [23:0] SampQ;
    logic               PushCoef;
    logic [4:0]         CoefAddr;
    logic signed [26:0] CoefI;
    logic signed [26:0] CoefQ;
    logic               PushOut;
    logic signed [31:0] FI;
    logic signed [31:0] FQ;

    modport master (
        output PushIn, SampI, SampQ, PushCoef, CoefAddr, CoefI, CoefQ,
        input  StopIn, PushOut, FI, FQ
    );

    modport slave (
        input  PushIn, SampI, SampQ, PushCoef, CoefAddr, CoefI, CoefQ,
        output StopIn, PushOut, FI, FQ
    );
endinterface

// File: rtl/firc_core.sv
// Complex 29-tap symmetric FIR: an 8-deep sample FIFO, a double-buffered coefficient bank
// and 5 two-stage complex multipliers reused over three tap groups per output.
module firc_core (
    input  logic  clk,
    input  logic  Reset,
    firc_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ROUND = 2'd3
    } state_t;

    // Round at bit 23 with a half-LSB offset and keep 32 bits (wraps, never saturates).
    function automatic logic signed [31:0] round_q23(input logic signed [59:0] v);
        return 32'((v + 60'sd4194304) >>> 23);
    endfunction

    state_t             state_q;
    logic [1:0]         sel_q;
    logic               drain_ph_q;
    logic               push_out_q;
    logic signed [31:0] fi_q;
    logic signed [31:0] fq_q;

    logic [3:0]         cnt_q;
    logic [2:0]         wr_ptr_q;
    logic [2:0]         rd_ptr_q;
    logic signed [23:0] fifo_si_q [8];
    logic signed [23:0] fifo_sq_q [8];
    logic signed [23:0] dl_si_q [29];
    logic signed [23:0] dl_sq_q [29];
    logic signed [26:0] sh_ci_q [15];
    logic signed [26:0] sh_cq_q [15];
    logic signed [26:0] ac_ci_q [15];
    logic signed [26:0] ac_cq_q [15];

    logic signed [24:0] op_pi_q [5];
    logic signed [24:0] op_pq_q [5];
    logic signed [26:0] op_ci_q [5];
    logic signed [26:0] op_cq_q [5];
    logic               op_vld_q;
    logic signed [52:0] mul_re_q [5];
    logic signed [52:0] mul_im_q [5];
    logic               mul_vld_q;
    logic signed [59:0] acc_re_q;
    logic signed [59:0] acc_im_q;

    logic               full_s;
    logic               push_s;
    logic               pull_s;
    logic [4:0]         tap_base_s;
    logic [4:0]         tap_idx_s [5];
    logic signed [24:0] pre_i_s [5];
    logic signed [24:0] pre_q_s [5];
    logic signed [26:0] cm_i_s [5];
    logic signed [26:0] cm_q_s [5];
    logic signed [52:0] mul_re_d [5];
    logic signed [52:0] mul_im_d [5];
    logic signed [59:0] sum_re_s;
    logic signed [59:0] sum_im_s;

    // A sample pushed this cycle only counts from the next cycle, so pull looks at the registered count.
    assign full_s = (cnt_q == 4'd8);
    assign push_s = bus.PushIn && !full_s;
    assign pull_s = (state_q == ST_IDLE) && (cnt_q != 4'd0);

    assign bus.StopIn  = full_s;
    assign bus.PushOut = push_out_q;
    assign bus.FI      = fi_q;
    assign bus.FQ      = fq_q;

    // Sample FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_q    <= 4'd0;
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            for (int k = 0; k < 8; k++) begin
                fifo_si_q[k] <= 24'sd0;
                fifo_sq_q[k] <= 24'sd0;
            end
        end else begin
            if (push_s) begin
                fifo_si_q[wr_ptr_q] <= bus.SampI;
                fifo_sq_q[wr_ptr_q] <= bus.SampQ;
                wr_ptr_q            <= wr_ptr_q + 3'd1;
            end
            if (pull_s) begin
                rd_ptr_q <= rd_ptr_q + 3'd1;
            end
            cnt_q <= cnt_q + {3'd0, push_s} - {3'd0, pull_s};
        end
    end

    // Shadow bank takes writes; the active bank snapshots it on each pull.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < 15; k++) begin
                sh_ci_q[k] <= 27'sd0;
                sh_cq_q[k] <= 27'sd0;
                ac_ci_q[k] <= 27'sd0;
                ac_cq_q[k] <= 27'sd0;
            end
        end else begin
            if (bus.PushCoef && (bus.CoefAddr < 5'd15)) begin
                sh_ci_q[bus.CoefAddr[3:0]] <= bus.CoefI;
                sh_cq_q[bus.CoefAddr[3:0]] <= bus.CoefQ;
            end
            if (pull_s) begin
                for (int k = 0; k < 15; k++) begin
                    ac_ci_q[k] <= sh_ci_q[k];
                    ac_cq_q[k] <= sh_cq_q[k];
                end
            end
        end
    end

    // Delay line: the FIFO head enters at tap 0 on every pull.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < 29; k++) begin
                dl_si_q[k] <= 24'sd0;
                dl_sq_q[k] <= 24'sd0;
            end
        end else if (pull_s) begin
            dl_si_q[0] <= fifo_si_q[rd_ptr_q];
            dl_sq_q[0] <= fifo_sq_q[rd_ptr_q];
            for (int k = 1; k < 29; k++) begin
                dl_si_q[k] <= dl_si_q[k-1];
                dl_sq_q[k] <= dl_sq_q[k-1];
            end
        end
    end

    // Tap-group select and symmetric pre-add; tap 14 is the unpaired centre tap.
    always_comb begin
        case (sel_q)
            2'd0:    tap_base_s = 5'd0;
            2'd1:    tap_base_s = 5'd5;
            2'd2:    tap_base_s = 5'd10;
            default: tap_base_s = 5'd0;
        endcase
        for (int j = 0; j < 5; j++) begin
            tap_idx_s[j] = tap_base_s + 5'(j);
            cm_i_s[j]    = ac_ci_q[tap_idx_s[j][3:0]];
            cm_q_s[j]    = ac_cq_q[tap_idx_s[j][3:0]];
            if (tap_idx_s[j] == 5'd14) begin
                pre_i_s[j] = {dl_si_q[14][23], dl_si_q[14]};
                pre_q_s[j] = {dl_sq_q[14][23], dl_sq_q[14]};
            end else begin
                pre_i_s[j] = {dl_si_q[tap_idx_s[j]][23], dl_si_q[tap_idx_s[j]]}
                           + {dl_si_q[5'd28 - tap_idx_s[j]][23], dl_si_q[5'd28 - tap_idx_s[j]]};
                pre_q_s[j] = {dl_sq_q[tap_idx_s[j]][23], dl_sq_q[tap_idx_s[j]]}
                           + {dl_sq_q[5'd28 - tap_idx_s[j]][23], dl_sq_q[5'd28 - tap_idx_s[j]]};
            end
        end
    end

    // Full-precision complex products and their per-group sums.
    always_comb begin
        sum_re_s = 60'sd0;
        sum_im_s = 60'sd0;
        for (int j = 0; j < 5; j++) begin
            mul_re_d[j] = 53'(op_ci_q[j]) * 53'(op_pi_q[j]) - 53'(op_cq_q[j]) * 53'(op_pq_q[j]);
            mul_im_d[j] = 53'(op_ci_q[j]) * 53'(op_pq_q[j]) + 53'(op_cq_q[j]) * 53'(op_pi_q[j]);
            sum_re_s    = sum_re_s + 60'(mul_re_q[j]);
            sum_im_s    = sum_im_s + 60'(mul_im_q[j]);
        end
    end

    // Operand stage, product stage and accumulator; the valid bits mark the three MUL groups.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            op_vld_q  <= 1'b0;
            mul_vld_q <= 1'b0;
            acc_re_q  <= 60'sd0;
            acc_im_q  <= 60'sd0;
            for (int j = 0; j < 5; j++) begin
                op_pi_q[j]  <= 25'sd0;
                op_pq_q[j]  <= 25'sd0;
                op_ci_q[j]  <= 27'sd0;
                op_cq_q[j]  <= 27'sd0;
                mul_re_q[j] <= 53'sd0;
                mul_im_q[j] <= 53'sd0;
            end
        end else begin
            op_vld_q  <= (state_q == ST_MUL);
            mul_vld_q <= op_vld_q;
            for (int j = 0; j < 5; j++) begin
                op_pi_q[j]  <= pre_i_s[j];
                op_pq_q[j]  <= pre_q_s[j];
                op_ci_q[j]  <= cm_i_s[j];
                op_cq_q[j]  <= cm_q_s[j];
                mul_re_q[j] <= mul_re_d[j];
                mul_im_q[j] <= mul_im_d[j];
            end
            if (pull_s) begin
                acc_re_q <= 60'sd0;
                acc_im_q <= 60'sd0;
            end else if (mul_vld_q) begin
                acc_re_q <= acc_re_q + sum_re_s;
                acc_im_q <= acc_im_q + sum_im_s;
            end
        end
    end

    // Control FSM with registered result and output strobe.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= 2'd0;
            drain_ph_q <= 1'b0;
            push_out_q <= 1'b0;
            fi_q       <= 32'sd0;
            fq_q       <= 32'sd0;
        end else begin
            push_out_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pull_s) begin
                        state_q <= ST_MUL;
                        sel_q   <= 2'd0;
                    end
                end
                ST_MUL: begin
                    if (sel_q == 2'd2) begin
                        state_q    <= ST_DRAIN;
                        drain_ph_q <= 1'b0;
                    end else begin
                        sel_q <= sel_q + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_ph_q) begin
                        state_q <= ST_ROUND;
                    end else begin
                        drain_ph_q <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    fi_q       <= round_q23(acc_re_q);
                    fq_q       <= round_q23(acc_im_q);
                    push_out_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_firc_core.sv
// Randomised bench for firc_core against a direct 29-tap complex convolution model,
// plus directed impulse, rotation, rounding, back-pressure, reset and coefficient cases.
module tb_firc_core;
    logic clk = 1'b0;
    logic Reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   last_cyc = 0;
    int   burst_n = 0;
    bit   burst_on = 1'b0;

    longint      mc_i [15];
    longint      mc_q [15];
    longint      hs_i [29];
    longint      hs_q [29];
    logic [63:0] exp_q [$];

    firc_if bus ();

    firc_core dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < 15; k++) begin
            mc_i[k] = 0;
            mc_q[k] = 0;
        end
        for (int n = 0; n < 29; n++) begin
            hs_i[n] = 0;
            hs_q[n] = 0;
        end
        exp_q.delete();
    endfunction

    // Output = sum over all 29 taps of h[n]*x[n], with h[n] = c[n] for n<=14 and c[28-n] above.
    function automatic void model_push(input logic signed [23:0] si, input logic signed [23:0] sq);
        longint yr;
        longint yi;
        int     k;
        for (int n = 28; n > 0; n--) begin
            hs_i[n] = hs_i[n-1];
            hs_q[n] = hs_q[n-1];
        end
        hs_i[0] = longint'(si);
        hs_q[0] = longint'(sq);
        yr = 0;
        yi = 0;
        for (int n = 0; n < 29; n++) begin
            k  = (n <= 14) ? n : 28 - n;
            yr = yr + mc_i[k] * hs_i[n] - mc_q[k] * hs_q[n];
            yi = yi + mc_i[k] * hs_q[n] + mc_q[k] * hs_i[n];
        end
        yr = (yr + 64'sd4194304) >>> 23;
        yi = (yi + 64'sd4194304) >>> 23;
        exp_q.push_back({yr[31:0], yi[31:0]});
    endfunction

    // Every output pulse is compared against the oldest expected result.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!Reset && bus.PushOut) begin
            n_out++;
            check_eq("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("model_fi", bus.FI, e[63:32]);
                check_eq("model_fq", bus.FQ, e[31:0]);
            end
            if (burst_on) begin
                if (burst_n > 0) check_eq("burst_spacing", cyc - last_cyc, 32'd7);
                burst_n++;
            end
            last_cyc = cyc;
        end
    end

    task automatic do_reset();
        Reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
    endtask

    task automatic write_coef(input logic [4:0] a, input logic signed [26:0] ci, input logic signed [26:0] cq);
        bus.PushCoef = 1'b1;
        bus.CoefAddr = a;
        bus.CoefI    = ci;
        bus.CoefQ    = cq;
        if (a < 5'd15) begin
            mc_i[a] = longint'(ci);
            mc_q[a] = longint'(cq);
        end
        @(posedge clk);
        #1 bus.PushCoef = 1'b0;
    endtask

    task automatic random_coefs();
        for (int k = 0; k < 15; k++) write_coef(5'(k), 27'($urandom), 27'($urandom));
    endtask

    task automatic push_one(input logic signed [23:0] si, input logic signed [23:0] sq);
        int waited = 0;
        while (bus.StopIn && waited < 200) begin
            @(posedge clk);
            #1 waited++;
        end
        check_eq("push_not_blocked", 32'(bus.StopIn), 32'd0);
        bus.PushIn = 1'b1;
        bus.SampI  = si;
        bus.SampQ  = sq;
        model_push(si, sq);
        @(posedge clk);
        #1 bus.PushIn = 1'b0;
    endtask

    // Holds PushIn high every cycle; pushes seen with StopIn high are dropped.
    task automatic push_stream(input int n_acc, input int max_cyc, output int acc, output bit stop_seen);
        logic signed [23:0] si;
        logic signed [23:0] sq;
        acc       = 0;
        stop_seen = 1'b0;
        for (int c = 0; c < max_cyc && acc < n_acc; c++) begin
            si         = 24'($urandom);
            sq         = 24'($urandom);
            bus.PushIn = 1'b1;
            bus.SampI  = si;
            bus.SampQ  = sq;
            if (bus.StopIn) begin
                stop_seen = 1'b1;
            end else begin
                model_push(si, sq);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        bus.PushIn = 1'b0;
    endtask

    task automatic wait_out(output logic [31:0] fi, output logic [31:0] fq, output int lat);
        lat = 0;
        fi  = 32'd0;
        fq  = 32'd0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.PushOut) begin
                fi  = bus.FI;
                fq  = bus.FQ;
                lat = n + 1;
                break;
            end
        end
        check_eq("out_seen", 32'(lat != 0), 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // One sample followed by nz zeros, each waited for; middle outputs must be zero.
    task automatic run_seq(input string tag, input logic signed [23:0] si, input logic signed [23:0] sq,
                           input int nz, input logic [31:0] f_fi, input logic [31:0] f_fq,
                           input logic [31:0] l_fi, input logic [31:0] l_fq);
        logic [31:0] fi;
        logic [31:0] fq;
        int          lat;
        push_one(si, sq);
        wait_out(fi, fq, lat);
        check_eq({tag, "_lat"}, lat, 32'd8);
        check_eq({tag, "_first_fi"}, fi, f_fi);
        check_eq({tag, "_first_fq"}, fq, f_fq);
        for (int n = 1; n <= nz; n++) begin
            push_one(24'sd0, 24'sd0);
            wait_out(fi, fq, lat);
            if (n == nz) begin
                check_eq({tag, "_last_fi"}, fi, l_fi);
                check_eq({tag, "_last_fq"}, fq, l_fq);
            end else begin
                check_eq({tag, "_mid_fi"}, fi, 32'd0);
                check_eq({tag, "_mid_fq"}, fq, 32'd0);
            end
        end
    endtask

    initial begin
        int          acc;
        bit          stop_seen;
        int          outs_before;
        logic [31:0] fi;
        logic [31:0] fq;
        int          lat;

        Reset        = 1'b1;
        bus.PushIn   = 1'b0;
        bus.SampI    = 24'sd0;
        bus.SampQ    = 24'sd0;
        bus.PushCoef = 1'b0;
        bus.CoefAddr = 5'd0;
        bus.CoefI    = 27'sd0;
        bus.CoefQ    = 27'sd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_pushout", 32'(bus.PushOut), 32'd0);
        check_eq("rst_fi", bus.FI, 32'd0);
        check_eq("rst_fq", bus.FQ, 32'd0);
        check_eq("rst_stopin", 32'(bus.StopIn), 32'd0);
        Reset = 1'b0;
        @(posedge clk);
        #1;

        write_coef(5'd0, 27'sh1000000, 27'sd0);
        run_seq("impulse", 24'sh400000, 24'sd0, 28, 32'h00800000, 32'd0, 32'h00800000, 32'd0);

        do_reset();
        write_coef(5'd0, 27'sd0, 27'sh1000000);
        run_seq("rotate", 24'sh400000, 24'sh200000, 0, 32'hFFC00000, 32'h00800000, 32'd0, 32'd0);

        do_reset();
        write_coef(5'd14, 27'sd1, 27'sd0);
        run_seq("round_half", 24'sh400000, 24'sd0, 14, 32'd0, 32'd0, 32'd1, 32'd0);

        do_reset();
        write_coef(5'd14, 27'sd1, 27'sd0);
        run_seq("round_low", 24'sh000001, 24'sd0, 14, 32'd0, 32'd0, 32'd0, 32'd0);

        // Coefficient rewritten while the first sample is already being computed.
        do_reset();
        write_coef(5'd0, 27'sh1000000, 27'sd0);
        write_coef(5'd20, 27'sh3ABCDEF, 27'sh1234567);
        push_one(24'sh100000, 24'sh080000);
        repeat (2) @(posedge clk);
        #1;
        write_coef(5'd0, 27'sh0800000, 27'sh0400000);
        push_one(24'sh100000, 24'sd0);
        wait_out(fi, fq, lat);
        check_eq("coef_old_fi", fi, 32'h00200000);
        check_eq("coef_old_fq", fq, 32'h00100000);
        wait_out(fi, fq, lat);
        check_eq("coef_new_fi", fi, 32'h00100000);
        check_eq("coef_new_fq", fq, 32'h00080000);
        wait_drain();

        // Back-to-back burst with dropped pushes while full.
        do_reset();
        random_coefs();
        burst_n  = 0;
        burst_on = 1'b1;
        push_stream(30, 1000, acc, stop_seen);
        check_eq("burst_accepted", acc, 32'd30);
        check_eq("burst_stop_seen", 32'(stop_seen), 32'd1);
        wait_drain();
        burst_on = 1'b0;
        check_eq("burst_outputs", burst_n, 32'd30);

        // Randomised streams with idle gaps and writes to unused coefficient addresses.
        for (int r = 0; r < 3; r++) begin
            random_coefs();
            for (int s = 0; s < 20; s++) begin
                push_one(24'($urandom), 24'($urandom));
                if ($urandom_range(0, 3) == 0) write_coef(5'($urandom_range(15, 31)), 27'($urandom), 27'($urandom));
                repeat ($urandom_range(0, 9)) @(posedge clk);
                #1;
            end
            wait_drain();
        end

        // Reset while the FIFO is full and a computation is in flight.
        random_coefs();
        push_stream(100, 14, acc, stop_seen);
        check_eq("pre_rst_stopin", 32'(bus.StopIn), 32'd1);
        Reset = 1'b1;
        model_clear();
        #1;
        check_eq("midrst_pushout", 32'(bus.PushOut), 32'd0);
        check_eq("midrst_fi", bus.FI, 32'd0);
        check_eq("midrst_fq", bus.FQ, 32'd0);
        check_eq("midrst_stopin", 32'(bus.StopIn), 32'd0);
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
        outs_before = n_out;
        repeat (40) @(posedge clk);
        #1;
        check_eq("no_out_after_rst", n_out - outs_before, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
